// File: rtl/pong_state_engine.sv
// Pong game state engine: serve/play/over FSM, ball physics with wall and paddle
// bounces, paddle movement and scoring. Everything advances one frame per update_screen
// tick, except the serve button latch, which samples every cycle.
module pong_state_engine #(
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int BALL_SIZE     = 8,
  parameter int PADDLE_W      = 8,
  parameter int PADDLE_H      = 64,
  parameter int PADDLE_MARGIN = 16,
  parameter int PADDLE_STEP   = 4,
  parameter int BALL_VEL      = 2,
  parameter int MAX_VEL       = 8,
  parameter int SPEEDUP_HITS  = 4,
  parameter int SERVE_DELAY   = 30,
  parameter int WIN_SCORE     = 7,
  parameter int SCORE_W       = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               update_screen,
  input  logic [1:0]         joy_up,
  input  logic [1:0]         joy_down,
  input  logic               serve_button,
  output logic [9:0]         ball_top,
  output logic [9:0]         ball_left,
  output logic [9:0]         paddle0_y,
  output logic [9:0]         paddle1_y,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [1:0]         game_state,
  output logic               game_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int HIT_W = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;
  localparam int DLY_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  // Pixel constants in the formats they are used in
  localparam logic [9:0] CENTER_TOP   = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0] CENTER_LEFT  = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] PADDLE_INIT  = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0] PADDLE_MAX   = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0] P_STEP       = 10'(PADDLE_STEP);
  localparam logic [9:0] BALL_TOP_MAX = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0] LEFT_STOP    = 10'(PADDLE_MARGIN + PADDLE_W);
  localparam logic [9:0] RIGHT_STOP   = 10'(SCREEN_W - PADDLE_MARGIN - PADDLE_W - BALL_SIZE);

  localparam logic signed [11:0] C_BALL     = 12'(BALL_SIZE);
  localparam logic signed [11:0] C_PAD_H    = 12'(PADDLE_H);
  localparam logic signed [11:0] C_SCREEN_H = 12'(SCREEN_H);
  localparam logic signed [11:0] C_SCREEN_W = 12'(SCREEN_W);
  localparam logic signed [11:0] C_LBOUND   = 12'(PADDLE_MARGIN + PADDLE_W);
  localparam logic signed [11:0] C_RBOUND   = 12'(SCREEN_W - PADDLE_MARGIN - PADDLE_W);

  localparam logic signed [4:0]  V_SERVE  = 5'(BALL_VEL);
  localparam logic signed [4:0]  V_MAX    = 5'(MAX_VEL);
  localparam logic [HIT_W-1:0]   HIT_LAST = HIT_W'(SPEEDUP_HITS - 1);
  localparam logic [DLY_W-1:0]   DLY_LAST = DLY_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  state_t             r_state;
  logic               r_game_over;
  logic               r_serve_flag;
  logic               r_serve_right;   // next serve heads toward the right player
  logic [9:0]         r_ball_top, r_ball_left, r_paddle0_y, r_paddle1_y;
  logic [SCORE_W-1:0] r_score0, r_score1;
  logic signed [4:0]  r_vel_x, r_vel_y;
  logic [HIT_W-1:0]   r_hit_cnt;       // paddle hits modulo SPEEDUP_HITS
  logic [DLY_W-1:0]   r_delay_cnt;

  logic signed [11:0] w_top, w_left, w_p0, w_p1, w_next_top, w_next_left;
  logic [9:0]         w_ball_top_nx, w_paddle0_nx, w_paddle1_nx;
  logic signed [4:0]  w_vel_y_nx, w_mag, w_mag_nx;
  logic [HIT_W-1:0]   w_hit_cnt_nx;
  logic [SCORE_W-1:0] w_score0_inc, w_score1_inc;
  logic               w_overlap0, w_overlap1, w_hit_left, w_hit_right;
  logic               w_miss_left, w_miss_right, w_speedup, w_point_wins, w_consume;

  // One paddle step toward the pressed direction, clamped to the playfield
  function automatic logic [9:0] move_paddle(input logic [9:0] y, input logic up,
                                             input logic down);
    logic [10:0] lowered;
    lowered = {1'b0, y} + {1'b0, P_STEP};
    if (up && !down)      return (y >= P_STEP) ? y - P_STEP : '0;
    else if (down && !up) return (lowered >= {1'b0, PADDLE_MAX}) ? PADDLE_MAX : lowered[9:0];
    return y;
  endfunction

  assign w_paddle0_nx = move_paddle(r_paddle0_y, joy_up[0], joy_down[0]);
  assign w_paddle1_nx = move_paddle(r_paddle1_y, joy_up[1], joy_down[1]);

  // Signed candidate positions so a step past zero is seen as negative, not a wrap
  assign w_top       = {2'b00, r_ball_top};
  assign w_left      = {2'b00, r_ball_left};
  assign w_p0        = {2'b00, r_paddle0_y};
  assign w_p1        = {2'b00, r_paddle1_y};
  assign w_next_top  = w_top  + {{7{r_vel_y[4]}}, r_vel_y};
  assign w_next_left = w_left + {{7{r_vel_x[4]}}, r_vel_x};

  // Collision and miss tests use the paddles as they stood before this frame
  assign w_overlap0   = (w_top + C_BALL > w_p0) && (w_top < w_p0 + C_PAD_H);
  assign w_overlap1   = (w_top + C_BALL > w_p1) && (w_top < w_p1 + C_PAD_H);
  assign w_hit_left   = r_vel_x[4] && (w_left >= C_LBOUND) && (w_next_left < C_LBOUND)
                        && w_overlap0;
  assign w_hit_right  = !r_vel_x[4] && (r_vel_x != '0) && (w_left + C_BALL <= C_RBOUND)
                        && (w_next_left + C_BALL > C_RBOUND) && w_overlap1;
  assign w_miss_left  = (w_next_left <= 12'sd0);
  assign w_miss_right = (w_next_left + C_BALL >= C_SCREEN_W);

  // Every SPEEDUP_HITS-th hit bumps the horizontal speed, capped at MAX_VEL
  assign w_mag        = r_vel_x[4] ? -r_vel_x : r_vel_x;
  assign w_speedup    = (r_hit_cnt == HIT_LAST);
  assign w_hit_cnt_nx = w_speedup ? '0 : r_hit_cnt + HIT_W'(1);
  assign w_mag_nx     = (w_speedup && w_mag < V_MAX) ? w_mag + 5'sd1 : w_mag;

  assign w_score0_inc = r_score0 + SCORE_W'(1);
  assign w_score1_inc = r_score1 + SCORE_W'(1);
  assign w_point_wins = w_miss_left ? (w_score1_inc == WIN) : (w_score0_inc == WIN);
  assign w_consume    = update_screen && r_serve_flag && (r_state == S_IDLE || r_state == S_OVER);

  // Vertical motion with top/bottom wall reflection
  always_comb begin
    // NOTE: defaults first so untaken branches never leave a value held (no latch).
    w_ball_top_nx = w_next_top[9:0];
    w_vel_y_nx    = r_vel_y;
    if (w_next_top < 12'sd0) begin
      w_ball_top_nx = '0;
      w_vel_y_nx    = -r_vel_y;
    end else if (w_next_top + C_BALL > C_SCREEN_H) begin
      w_ball_top_nx = BALL_TOP_MAX;
      w_vel_y_nx    = -r_vel_y;
    end
  end

  // Game FSM with ball, paddle and score registers, advanced once per frame tick
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_game_over   <= 1'b0;
      r_serve_flag  <= 1'b0;
      r_serve_right <= 1'b1;
      r_ball_top    <= CENTER_TOP;
      r_ball_left   <= CENTER_LEFT;
      r_paddle0_y   <= PADDLE_INIT;
      r_paddle1_y   <= PADDLE_INIT;
      r_score0      <= '0;
      r_score1      <= '0;
      r_vel_x       <= V_SERVE;
      r_vel_y       <= V_SERVE;
      r_hit_cnt     <= '0;
      r_delay_cnt   <= '0;
    end else begin
      // NOTE: non-blocking updates make every test in this frame see pre-edge state.
      r_serve_flag <= (r_serve_flag && !w_consume) || serve_button;
      if (update_screen) begin
        case (r_state)
          S_IDLE: begin
            if (r_serve_flag) begin
              r_state       <= S_SERVE;
              r_serve_right <= 1'b1;
              r_delay_cnt   <= '0;
              r_hit_cnt     <= '0;
              r_ball_top    <= CENTER_TOP;
              r_ball_left   <= CENTER_LEFT;
            end
          end
          S_SERVE: begin
            r_paddle0_y <= w_paddle0_nx;
            r_paddle1_y <= w_paddle1_nx;
            if (r_delay_cnt == DLY_LAST) begin
              r_state   <= S_PLAY;
              r_vel_x   <= r_serve_right ? V_SERVE : -V_SERVE;
              r_vel_y   <= V_SERVE;
              r_hit_cnt <= '0;
            end else begin
              r_delay_cnt <= r_delay_cnt + DLY_W'(1);
            end
          end
          S_PLAY: begin
            r_paddle0_y <= w_paddle0_nx;
            r_paddle1_y <= w_paddle1_nx;
            if (w_hit_left || w_hit_right) begin
              r_ball_top  <= w_ball_top_nx;
              r_vel_y     <= w_vel_y_nx;
              r_ball_left <= w_hit_left ? LEFT_STOP : RIGHT_STOP;
              r_vel_x     <= w_hit_left ? w_mag_nx : -w_mag_nx;
              r_hit_cnt   <= w_hit_cnt_nx;
            end else if (w_miss_left || w_miss_right) begin
              r_ball_top    <= CENTER_TOP;
              r_ball_left   <= CENTER_LEFT;
              r_delay_cnt   <= '0;
              r_hit_cnt     <= '0;
              r_serve_right <= w_miss_right;
              if (w_miss_left) r_score1 <= w_score1_inc;
              else             r_score0 <= w_score0_inc;
              if (w_point_wins) begin
                r_state     <= S_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state <= S_SERVE;
              end
            end else begin
              r_ball_top  <= w_ball_top_nx;
              r_vel_y     <= w_vel_y_nx;
              r_ball_left <= w_next_left[9:0];
            end
          end
          S_OVER: begin
            if (r_serve_flag) begin
              r_state     <= S_IDLE;
              r_game_over <= 1'b0;
              r_score0    <= '0;
              r_score1    <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ball_top   = r_ball_top;
  assign ball_left  = r_ball_left;
  assign paddle0_y  = r_paddle0_y;
  assign paddle1_y  = r_paddle1_y;
  assign score0     = r_score0;
  assign score1     = r_score1;
  assign game_state = r_state;
  assign game_over  = r_game_over;

endmodule

// File: doc/pong_state_engine.md
PONG_STATE_ENGINE -- requirements
Module: pong_state_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  SCREEN_W 640 playfield width, pixels
  SCREEN_H 480 playfield height, pixels
  BALL_SIZE 8 ball side, pixels
  PADDLE_W 8 paddle width
  PADDLE_H 64 paddle height
  PADDLE_MARGIN 16 gap between screen edge and paddle outer face
  PADDLE_STEP 4 paddle pixels per frame
  BALL_VEL 2 serve speed, pixels per frame per axis
  MAX_VEL 8 speed cap, |vel_x|
  SPEEDUP_HITS 4 paddle hits per +1 |vel_x|
  SERVE_DELAY 30 frames held in SERVE
  WIN_SCORE 7 points to win
  SCORE_W 4 score width
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
  clock input 1 single system clock, all state on rising edge
  reset input 1 synchronous, active-low reset
  update_screen input 1 one-cycle frame tick; game advances only on cycles where it is 1
  joy_up input 2 bit p = player p up
  joy_down input 2 bit p = player p down
  serve_button input 1 arcade button, any pulse width >= 1 cycle
  ball_top output 10 ball top row
  ball_left output 10 ball left column
  paddle0_y output 10 left paddle top row
  paddle1_y output 10 right paddle top row
  score0 output SCORE_W left player score
  score1 output SCORE_W right player score
  game_state output 2 IDLE=0, SERVE=1, PLAY=2, OVER=3
  game_over output 1 high exactly when game_state==OVER

Function
REQ-003 SHALL update ball, paddles, scores and FSM only on cycles with update_screen=1, except for the serve latch.
REQ-004 SHALL latch serve_button high on any cycle into a sticky flag, cleared only when consumed by an FSM transition.
REQ-005 FSM: IDLE->SERVE on a frame with the flag set; SERVE->PLAY after SERVE_DELAY frames; PLAY->SERVE on a point; PLAY->OVER when a point makes a score equal WIN_SCORE; OVER->IDLE on a frame with the flag set, clearing both scores.
REQ-006 In IDLE and SERVE: ball held centred, ((SCREEN_H-BALL_SIZE)/2, (SCREEN_W-BALL_SIZE)/2).
REQ-007 On entering PLAY: vel_y=+BALL_VEL; vel_x=+BALL_VEL after reset or IDLE, else toward the player who conceded the last point.
REQ-008 PLAY position math SHALL use signed 12-bit intermediates; vel_x and vel_y are signed 5-bit; no unsigned wrap.
REQ-009 Walls: if next top < 0, set ball_top=0 and negate vel_y; if next top+BALL_SIZE > SCREEN_H, set ball_top=SCREEN_H-BALL_SIZE and negate vel_y.
REQ-010 Left paddle hit: vel_x<0, current left >= PADDLE_MARGIN+PADDLE_W, next left < that bound, and rows overlap (ball_top+BALL_SIZE > paddle0_y and ball_top < paddle0_y+PADDLE_H) -> ball_left=PADDLE_MARGIN+PADDLE_W, negate vel_x. Right paddle mirrored at SCREEN_W-PADDLE_MARGIN-PADDLE_W.
REQ-011 Hit counter SHALL increment per paddle hit. Every SPEEDUP_HITS hits, |vel_x| +=1, saturating at MAX_VEL. Counter and speed return to serve values at each SERVE.
REQ-012 Miss: next left <= 0 -> score1+1; next left+BALL_SIZE >= SCREEN_W -> score0+1. Paddle test takes priority over miss test in the same frame.
REQ-013 Collision tests SHALL use pre-frame (registered) paddle positions. Paddle moves from the same frame take effect next frame.
REQ-014 Paddles move in SERVE and PLAY only. Up xor down -> move PADDLE_STEP, saturating at 0 / SCREEN_H-PADDLE_H. Both or neither pressed -> hold.
REQ-015 In OVER, positions and scores SHALL be frozen; update_screen has no effect except to consume the serve flag.

Reset
REQ-016 reset=0 at a rising edge SHALL override update_screen and all inputs, with these values:
  game_state=IDLE, game_over=0, serve flag=0
  ball_top=236, ball_left=316, paddle0_y=paddle1_y=208 (defaults)
  score0=score1=0, vel_x=+BALL_VEL, vel_y=+BALL_VEL, hit count=0, delay count=0
REQ-017 Reset asserted mid-PLAY SHALL give the REQ-016 values on the next edge, with no partial update.

Verification
REQ-018 Reset held low 2 cycles during PLAY -> outputs 236/316/208/208, scores 0, game_state=0.
REQ-019 serve_button 1-cycle pulse between ticks, then a tick -> SERVE; after 30 ticks -> PLAY; first PLAY tick -> ball_top=238, ball_left=318.
REQ-020 ball_top=1, vel_y=-2, tick -> ball_top=0, vel_y=+2; then 4 right-paddle hits at vel_x=2 -> |vel_x|=3.
REQ-021 paddle1_y=0, ball at right edge, no overlap -> score0=1, SERVE, ball recentred; next serve vel_x=+2.
REQ-022 joy_up[0] held for 60 ticks -> paddle0_y=0, no wrap. joy_up and joy_down both held -> paddle holds.
REQ-023 score0=6, left scores -> score0=7, OVER, game_over=1; ticks ignored; serve pulse then tick -> IDLE, scores 0.
